ysyx_23060171_trap_ctrl: RTL
============================

// Module: ysyx_23060171_trap_ctrl
// PURPOSE
//  Sequences machine-mode trap entry (ECALL/EBREAK/exception) and exit (MRET) over
//  the single CSR file write port, and arbitrates that port against ordinary
//  CSR-instruction writes from EXU. Sits between IDU/EXU and the CSR file; issues a
//  PC redirect to IFU when a trap sequence completes. One CSR write per cycle.
// PARAMETERS
//  ADDR_WIDTH  12  CSR address width
//  DATA_WIDTH  32  CSR/PC data width
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst_n          in   1   asynchronous active-low reset
//  trap_valid     in   1   trap request (valid/ready handshake)
//  trap_ready     out  1   high only in IDLE
//  trap_is_mret   in   1   1=MRET, 0=trap entry
//  trap_pc        in   DW  PC of the trapping instruction
//  trap_cause     in   8   mcause code (ECALL-M=11, EBREAK=3)
//  inst_wen       in   1   EXU CSR-instruction write request
//  inst_waddr     in   AW  EXU CSR write address
//  inst_wdata     in   DW  EXU CSR write data
//  inst_ready     out  1   EXU write accepted this cycle
//  csr_wen        out  1   CSR file write enable
//  csr_waddr      out  AW  CSR file write address
//  csr_wdata      out  DW  CSR file write data
//  csr_raddr      out  AW  CSR file read address (read is combinational)
//  csr_rdata      in   DW  CSR file read data
//  redirect_valid out  1   new PC available for IFU
//  redirect_pc    out  DW  target PC (mtvec or mepc)
//  redirect_ready in   1   IFU accepts redirect
//  busy           out  1   high in every state except IDLE (stalls front end)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; csr_wen=0, redirect_valid=0, redirect_pc=0,
//   latched pc/cause=0, busy=0. Reset mid-sequence aborts it; no partial write issued after.
//  Handshake: request accepted when trap_valid && trap_ready at posedge; trap_pc,
//   trap_cause, trap_is_mret latched then. Redirect held stable until redirect_ready.
//  FSM states: IDLE, W_EPC, W_CAUSE, W_STATUS, R_VEC, M_STATUS, R_EPC, REDIR.
//   IDLE    : csr_wen = inst_wen, csr_waddr/wdata = inst_*; inst_ready = inst_wen.
//             On accept: entry -> W_EPC, mret -> M_STATUS. A trap accept and inst_wen
//             in the same cycle: both proceed (inst write lands this cycle, it is older).
//   W_EPC   : write 0x341 <= latched pc                              -> W_CAUSE
//   W_CAUSE : write 0x342 <= {24'b0, latched cause}                 -> W_STATUS
//   W_STATUS: raddr 0x300; write 0x300 <= rdata with MPIE(7)=MIE(3), MIE=0,
//             MPP(12:11)=2'b11                                      -> R_VEC
//   R_VEC   : raddr 0x305; redirect_pc <= {rdata[DW-1:2],2'b00}     -> REDIR
//   M_STATUS: raddr 0x300; write 0x300 <= rdata with MIE=MPIE, MPIE=1, MPP=2'b11 -> R_EPC
//   R_EPC   : raddr 0x341; redirect_pc <= rdata                     -> REDIR
//   REDIR   : redirect_valid=1; on redirect_ready -> IDLE (valid drops next cycle).
//  Outside IDLE: csr_wen driven only by the FSM; inst_ready=0 (EXU holds request).
//  csr_wen=0 in R_VEC, R_EPC, REDIR. csr_raddr=0x300 when not otherwise specified.
//  Latency: entry accept->redirect_valid = 5 cycles; MRET accept->redirect_valid = 3.
//  trap_valid during busy is ignored (trap_ready=0), never dropped by IDU.
//  Read-modify-write uses value in CSR at that cycle (includes earlier FSM writes).
// TESTING
//  1 ECALL pc=0x8000_0010 cause=11, mtvec=0x8000_0100, mstatus=0x1808 -> writes
//    mepc=0x8000_0010, mcause=0xB, mstatus=0x1880; redirect_pc=0x8000_0100 at cycle 5.
//  2 MRET, mepc=0x8000_0014, mstatus=0x1880 -> mstatus=0x1888, redirect 0x8000_0014
//    at cycle 3; redirect_ready held low 4 cycles -> valid/pc stable, then IDLE.
//  3 inst_wen (mtvec<=0x8000_0200) same cycle as ECALL accept -> inst write lands,
//    trap uses redirect 0x8000_0200; inst_wen raised while busy -> inst_ready=0 until IDLE.
//  4 rst_n low during W_CAUSE -> immediate IDLE, no further csr_wen, redirect_valid=0;
//    mcause unchanged.
//  5 mtvec=0x8000_0103 -> redirect_pc=0x8000_0100; back-to-back ECALL then MRET
//    restores mstatus.MIE to original value.

Source files
------------

// File: rtl/ysyx_23060171_trap_ctrl.sv
// Machine-mode trap entry/MRET sequencer that owns the CSR write port and
// arbitrates it against EXU CSR-instruction writes.
module ysyx_23060171_trap_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  trap_valid,
    output logic                  trap_ready,
    input  logic                  trap_is_mret,
    input  logic [DATA_WIDTH-1:0] trap_pc,
    input  logic [7:0]            trap_cause,
    input  logic                  inst_wen,
    input  logic [ADDR_WIDTH-1:0] inst_waddr,
    input  logic [DATA_WIDTH-1:0] inst_wdata,
    output logic                  inst_ready,
    output logic                  csr_wen,
    output logic [ADDR_WIDTH-1:0] csr_waddr,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic [ADDR_WIDTH-1:0] csr_raddr,
    input  logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  redirect_ready,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] MSTATUS = ADDR_WIDTH'('h300);
    localparam logic [ADDR_WIDTH-1:0] MTVEC   = ADDR_WIDTH'('h305);
    localparam logic [ADDR_WIDTH-1:0] MEPC    = ADDR_WIDTH'('h341);
    localparam logic [ADDR_WIDTH-1:0] MCAUSE  = ADDR_WIDTH'('h342);

    typedef enum logic [2:0] {
        IDLE, W_EPC, W_CAUSE, W_STATUS, R_VEC, M_STATUS, R_EPC, REDIR
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [7:0]            cause_q;
    logic [DATA_WIDTH-1:0] status_entry;
    logic [DATA_WIDTH-1:0] status_mret;

    assign trap_ready = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc_q           <= '0;
            cause_q        <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_valid) begin
                        pc_q    <= trap_pc;
                        cause_q <= trap_cause;
                        state   <= trap_is_mret ? M_STATUS : W_EPC;
                    end
                end
                W_EPC:    state <= W_CAUSE;
                W_CAUSE:  state <= W_STATUS;
                W_STATUS: state <= R_VEC;
                R_VEC: begin
                    redirect_pc    <= {csr_rdata[DATA_WIDTH-1:2], 2'b00};
                    redirect_valid <= 1'b1;
                    state          <= REDIR;
                end
                M_STATUS: state <= R_EPC;
                R_EPC: begin
                    redirect_pc    <= csr_rdata;
                    redirect_valid <= 1'b1;
                    state          <= REDIR;
                end
                REDIR: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // mstatus read-modify-write images for trap entry and MRET
    always_comb begin
        status_entry        = csr_rdata;
        status_entry[7]     = csr_rdata[3];
        status_entry[3]     = 1'b0;
        status_entry[12:11] = 2'b11;
        status_mret         = csr_rdata;
        status_mret[3]      = csr_rdata[7];
        status_mret[7]      = 1'b1;
        status_mret[12:11]  = 2'b11;
    end

    // Write port is combinational so IDLE passes EXU writes through in-cycle
    always_comb begin
        csr_wen    = 1'b0;
        csr_waddr  = MSTATUS;
        csr_wdata  = '0;
        csr_raddr  = MSTATUS;
        inst_ready = 1'b0;
        case (state)
            IDLE: begin
                csr_wen    = inst_wen;
                csr_waddr  = inst_waddr;
                csr_wdata  = inst_wdata;
                inst_ready = inst_wen;
            end
            W_EPC: begin
                csr_wen   = 1'b1;
                csr_waddr = MEPC;
                csr_wdata = pc_q;
            end
            W_CAUSE: begin
                csr_wen   = 1'b1;
                csr_waddr = MCAUSE;
                csr_wdata = {{(DATA_WIDTH-8){1'b0}}, cause_q};
            end
            W_STATUS: begin
                csr_wen   = 1'b1;
                csr_waddr = MSTATUS;
                csr_wdata = status_entry;
            end
            R_VEC:    csr_raddr = MTVEC;
            M_STATUS: begin
                csr_wen   = 1'b1;
                csr_waddr = MSTATUS;
                csr_wdata = status_mret;
            end
            R_EPC:    csr_raddr = MEPC;
            default: ;
        endcase
    end

endmodule
